alu_seq_responder: RTL
======================

// Module: alu_seq_responder
// PURPOSE
//  Request/response ALU engine for the Phase 1 datapath: accepts {opcode, a, b} over a valid/ready
//  request channel, computes the result, and returns it over a valid/ready response channel.
//  Single-cycle ops finish in 1 cycle. MUL uses iterative Booth radix-2; DIV uses non-restoring division.
//  Sits between the control unit (initiator) and the HI/LO/Z registers (consumers of result).
// PARAMETERS
//  WIDTH      32  operand width; result is 2*WIDTH ({HI,LO})
//  CNT_W      6   iteration counter width (must hold WIDTH)
// PORTS
//  clock        in   1        rising-edge clock
//  clear_n      in   1        asynchronous active-low reset
//  req_valid    in   1        request present
//  req_ready    out  1        engine can accept (high only in IDLE)
//  req_opcode   in   4        0 OR,1 AND,2 NOT,3 ADD,4 SUB,5 NEG,6 MUL,7 DIV,8 SHL,9 SHR,10 SHRA,11 ROL,12 ROR
//  req_a        in   WIDTH    operand A
//  req_b        in   WIDTH    operand B (shift/rotate amount = b[4:0])
//  resp_valid   out  1        result available
//  resp_ready   in   1        consumer takes result
//  resp_result  out  2*WIDTH  {HI,LO}; HI=0 for all non-MUL/DIV ops
//  resp_err     out  1        illegal opcode (13-15), or div-by-zero when macro is defined
// BEHAVIOUR
//  - Reset (async, clear_n=0): state=IDLE; req_ready=1; resp_valid=0; resp_result=0; resp_err=0; counter=0.
//  - FSM: IDLE -> DONE (single-cycle/illegal op) | MUL | DIV; MUL -> DONE; DIV -> FIXUP -> DONE; DONE -> IDLE.
//  - Accept: req_valid&req_ready at edge N latches opcode/operands; req_ready drops the same edge.
//  - Latency (resp_valid first high after edge): logic/arith/shift N+1; MUL N+33; DIV N+34 (32 iter + sign fixup).
//  - DONE: resp_valid=1; resp_result/resp_err stable until resp_valid&resp_ready; that edge -> IDLE.
//    No accept in the same cycle as a response handshake (min 2 cycles per op).
//  - Arithmetic: ADD/SUB/NEG mod 2^WIDTH, no flags; NOT = ~a; NEG = 0-a.
//  - MUL signed: {HI,LO} = full 64-bit two's-complement product a*b.
//  - DIV signed, truncating toward zero: LO=quotient, HI=remainder (sign of dividend).
//    Magnitudes divided, then sign-corrected in FIXUP. 0x80000000 / -1 -> LO=0x80000000, HI=0.
//  - SHL/SHR logical, SHRA arithmetic, ROL/ROR by b[4:0]; amount 0 returns a unchanged.
//  - Illegal opcode: result 0, resp_err=1, latency N+1.
//  - req_* changes while busy are ignored (operands latched). resp_ready ignored outside DONE.
//  - clear_n asserted mid-MUL/DIV/DONE: operation and pending result discarded; back to reset values.
// CONFIGURATION
//  ALU_SEQ_DIV0_EARLY_EN
//   defined:   DIV with b=0 skips iteration; resp_valid at N+1, result {HI=a, LO=32'hFFFF_FFFF}, resp_err=1.
//   undefined: DIV with b=0 runs the full N+34 latency and returns the same {a, 32'hFFFF_FFFF} with resp_err=0.
// STRUCTURE
//  - Package alu_seq_pkg: opcode localparams (OP_OR..OP_ROR), state enum (IDLE, MUL, DIV, FIXUP, DONE),
//    and the {HI,LO} result struct/width constant.
//  - Sub-module alu_comb_ops: purely combinational single-cycle ops (logic, add/sub/neg, shifts/rotates).
//  - Top holds the FSM, iteration counter, Booth accumulator/multiplier regs, and divider remainder/quotient regs.
// TESTING
//  1. Reset mid-MUL: a=20,b=5 accepted, clear_n low at cycle 10 -> req_ready=1, resp_valid=0; next op runs normally.
//  2. Single-cycle sweep: a=20,b=5 -> OR 21, AND 4, NOT 0xFFFFFFEB, ADD 25, SUB 15, NEG 0xFFFFFFEC; each N+1, HI=0.
//  3. Shifts, a=0xB2, b=2 -> SHL 0x2C8, SHR 0x2C, ROL 0x2C8.
//     Same shifts with a=0x80000001: SHRA 0xE0000000, ROR 0x60000000.
//  4. MUL: 20*5 -> {0,100} at N+33; -3*7 -> 64'hFFFF_FFFF_FFFF_FFEB; 0xFFFFFFFF*0xFFFFFFFF -> {0,1}.
//  5. DIV: 20/5 -> LO=4,HI=0 at N+34; -7/2 -> LO=-3,HI=-1; 7/-2 -> LO=-3,HI=1.
//     Backpressure: hold resp_ready=0 for 5 cycles -> result stable, req_ready=0 throughout.
//  6. Edge cases: opcode 14 -> result 0, resp_err=1 at N+1.
//     DIV 9/0 -> {9, 0xFFFFFFFF}; resp_err and latency per ALU_SEQ_DIV0_EARLY_EN (run both builds).

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and result layout for the sequential ALU responder.
package alu_seq_pkg;

  localparam int DATA_W = 32;
  localparam int RES_W  = 2 * DATA_W;

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_NEG  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SHRA = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } res_t;

endpackage

// File: rtl/alu_comb_ops.sv
// Single-cycle ALU ops: logic, add/sub/neg, shifts and rotates. MUL/DIV decode as legal, zero result.
module alu_comb_ops #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             illegal
);
  import alu_seq_pkg::*;

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]  sh;
  logic [WIDTH-1:0] rol, ror;

  assign sh  = b[SH_W-1:0];
  // A shift by WIDTH yields zero, so amount 0 collapses to a unchanged.
  assign rol = (a << sh) | (a >> (WIDTH - int'(sh)));
  assign ror = (a >> sh) | (a << (WIDTH - int'(sh)));

  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_NOT:  y = ~a;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_NEG:  y = '0 - a;
      OP_MUL,
      OP_DIV:  y = '0;
      OP_SHL:  y = a << sh;
      OP_SHR:  y = a >> sh;
      OP_SHRA: y = $signed(a) >>> sh;
      OP_ROL:  y = rol;
      OP_ROR:  y = ror;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_responder.sv
// Valid/ready ALU engine: Booth radix-2 MUL, non-restoring DIV with sign fixup.
// Option macro ALU_SEQ_DIV0_EARLY_EN: DIV by zero completes in one cycle and flags resp_err.
module alu_seq_responder #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_opcode,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] resp_result,
  output logic               resp_err
);
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_DIV0_EARLY_EN
  localparam bit DIV0_EARLY = 1'b1;
`else
  localparam bit DIV0_EARLY = 1'b0;
`endif

  state_t state, state_nxt;

  logic [3:0]              op_q;
  logic [WIDTH-1:0]        a_q, b_q;
  logic [CNT_W-1:0]        cnt;
  // acc/mq form the {A,Q} pair shared by Booth and the divider; two guard bits absorb MIN operands.
  logic signed [WIDTH+1:0] acc, m_q;
  logic [WIDTH-1:0]        mq;
  logic                    q_m1;
  logic                    res_vld;

  logic                    accept, last_iter;
  logic [WIDTH-1:0]        a_abs, b_abs, comb_y, quo_s, rem_s;
  logic                    comb_ill, fin_err;
  logic signed [WIDTH+1:0] booth_sum, div_sh, div_nxt, rem_fix;
  logic [2*WIDTH-1:0]      fin_res;

  assign accept    = req_valid & req_ready;
  assign last_iter = (cnt == CNT_W'(WIDTH-1));
  assign a_abs     = req_a[WIDTH-1] ? ('0 - req_a) : req_a;
  assign b_abs     = req_b[WIDTH-1] ? ('0 - req_b) : req_b;

  alu_comb_ops #(.WIDTH(WIDTH)) u_ops (
    .op(op_q), .a(a_q), .b(b_q), .y(comb_y), .illegal(comb_ill)
  );

  always_comb begin
    case ({mq[0], q_m1})
      2'b01:   booth_sum = acc + m_q;
      2'b10:   booth_sum = acc - m_q;
      default: booth_sum = acc;
    endcase
    div_sh  = {acc[WIDTH:0], mq[WIDTH-1]};
    div_nxt = acc[WIDTH+1] ? (div_sh + m_q) : (div_sh - m_q);
    rem_fix = acc[WIDTH+1] ? (acc + m_q) : acc;
    quo_s   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? ('0 - mq) : mq;
    rem_s   = a_q[WIDTH-1] ? ('0 - rem_fix[WIDTH-1:0]) : rem_fix[WIDTH-1:0];
  end

  always_comb begin
    fin_res = {{WIDTH{1'b0}}, comb_y};
    fin_err = comb_ill;
    if (op_q == OP_MUL || op_q == OP_DIV) begin
      fin_res = {acc[WIDTH-1:0], mq};
      fin_err = 1'b0;
      if (DIV0_EARLY && op_q == OP_DIV && b_q == '0) begin
        fin_res = {a_q, {WIDTH{1'b1}}};
        fin_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (req_opcode == OP_MUL)
          state_nxt = MUL;
        else if (req_opcode == OP_DIV && !(DIV0_EARLY && req_b == '0))
          state_nxt = DIV;
        else
          state_nxt = DONE;
      end
      MUL:     if (last_iter) state_nxt = DONE;
      DIV:     if (last_iter) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    if (res_vld && resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE) && res_vld;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt         <= '0;
      acc         <= '0;
      m_q         <= '0;
      mq          <= '0;
      q_m1        <= 1'b0;
      res_vld     <= 1'b0;
      resp_result <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q    <= req_opcode;
          a_q     <= req_a;
          b_q     <= req_b;
          cnt     <= '0;
          acc     <= '0;
          q_m1    <= 1'b0;
          res_vld <= 1'b0;
          if (req_opcode == OP_DIV) begin
            mq  <= a_abs;
            m_q <= {2'b00, b_abs};
          end else begin
            mq  <= req_a;
            m_q <= {{2{req_b[WIDTH-1]}}, req_b};
          end
        end
        MUL: begin
          acc  <= {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
          mq   <= {booth_sum[0], mq[WIDTH-1:1]};
          q_m1 <= mq[0];
          cnt  <= cnt + 1'b1;
        end
        DIV: begin
          acc <= div_nxt;
          mq  <= {mq[WIDTH-2:0], ~div_nxt[WIDTH+1]};
          cnt <= cnt + 1'b1;
        end
        FIXUP: begin
          if (b_q == '0) begin
            acc <= {2'b00, a_q};
            mq  <= '1;
          end else begin
            acc <= {2'b00, rem_s};
            mq  <= quo_s;
          end
        end
        DONE: begin
          if (!res_vld) begin
            res_vld     <= 1'b1;
            resp_result <= fin_res;
            resp_err    <= fin_err;
          end else if (resp_ready) begin
            res_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
